// File: rtl/keypad_digit_buffer_if.sv
// Digit hand-off bundle between the keypad digit buffer and the countdown timer.
interface keypad_digit_buffer_if;
   logic [15:0] digits;
   logic [2:0]  digit_count;
   logic        load_req;
   logic        load_ack;
   logic        load_done;

   modport master (
      output digits,
      output digit_count,
      output load_req,
      output load_done,
      input  load_ack
   );

   modport slave (
      input  digits,
      input  digit_count,
      input  load_req,
      input  load_done,
      output load_ack
   );
endinterface

// File: rtl/keypad_digit_buffer.sv
// Keypad digit buffer: synchronises and debounces the BCD encoder output,
// accepts one digit per key press into a 4-digit MM:SS buffer, and hands the
// buffer to the countdown timer over a req/ack handshake.
//
// state   | meaning
// --------+---------------------------------------------------------------
// S_IDLE  | buffer empty, waiting for the first digit
// S_ENTRY | 1..4 digits held; start validates and hands off
// S_LOAD  | load_req high, encoder disabled, waiting for the timer's ack
module keypad_digit_buffer #(
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int CNT_W           = 8
) (
   input  logic                          clk,
   input  logic                          resetn,
   input  logic [3:0]                    bcd_i,
   input  logic                          valid_data_i,
   input  logic                          clear_i,
   input  logic                          start_i,
   output logic                          enablen_o,
   output logic                          error_o,
   keypad_digit_buffer_if.master         tmr
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ENTRY = 2'd1,
      S_LOAD  = 2'd2
   } state_t;

   localparam logic [CNT_W-1:0] CNT_TC = CNT_W'(DEBOUNCE_CYCLES - 1);

   state_t      state_q, state_d;
   logic        v_s1_q, v_s2_q;
   logic [3:0]  bcd_s1_q, bcd_s2_q;
   logic [CNT_W-1:0] cnt_q;
   logic        accepted_q;
   logic        accept;
   logic [15:0] digits_q, digits_d;
   logic [2:0]  count_q, count_d;
   logic        load_done_q, load_done_d;
   logic        error_q, error_d;
   logic        load_req_q, load_req_d;
   logic        enablen_q, enablen_d;
   logic        start_bad;

   // Two-flop synchroniser; valid and bcd move in lockstep so a digit is never
   // paired with a flag from a different cycle.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         v_s1_q   <= 1'b0;
         v_s2_q   <= 1'b0;
         bcd_s1_q <= 4'd0;
         bcd_s2_q <= 4'd0;
      end else begin
         v_s1_q   <= valid_data_i;
         v_s2_q   <= v_s1_q;
         bcd_s1_q <= bcd_i;
         bcd_s2_q <= bcd_s1_q;
      end
   end

   assign accept = v_s2_q && !accepted_q && (cnt_q == CNT_TC);

   // Debounce: count stable-high cycles; the accepted flag consumes the press
   // until the key is released, so a held key yields a single digit.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         cnt_q      <= '0;
         accepted_q <= 1'b0;
      end else if (!v_s2_q) begin
         cnt_q      <= '0;
         accepted_q <= 1'b0;
      end else if (!accepted_q) begin
         if (accept) accepted_q <= 1'b1;
         else        cnt_q      <= cnt_q + CNT_W'(1);
      end
   end

   assign start_bad = (state_q == S_IDLE) || (digits_q == 16'h0000) ||
                      (digits_q[7:4] > 4'd5);

   // State register plus the buffer/pulse registers that move with it.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q     <= S_IDLE;
         digits_q    <= 16'h0000;
         count_q     <= 3'd0;
         load_done_q <= 1'b0;
         error_q     <= 1'b0;
         load_req_q  <= 1'b0;
         enablen_q   <= 1'b1;
      end else begin
         state_q     <= state_d;
         digits_q    <= digits_d;
         count_q     <= count_d;
         load_done_q <= load_done_d;
         error_q     <= error_d;
         load_req_q  <= load_req_d;
         enablen_q   <= enablen_d;
      end
   end

   // Next state and buffer update; clear beats ack beats start beats a digit.
   always_comb begin
      state_d     = state_q;
      digits_d    = digits_q;
      count_d     = count_q;
      load_done_d = 1'b0;
      error_d     = 1'b0;
      if (clear_i) begin
         state_d  = S_IDLE;
         digits_d = 16'h0000;
         count_d  = 3'd0;
      end else begin
         case (state_q)
            S_LOAD: begin
               if (tmr.load_ack) begin
                  state_d     = S_IDLE;
                  digits_d    = 16'h0000;
                  count_d     = 3'd0;
                  load_done_d = 1'b1;
               end
            end
            S_IDLE, S_ENTRY: begin
               if (start_i) begin
                  if (start_bad) error_d = 1'b1;
                  else           state_d = S_LOAD;
               end else if (accept && (bcd_s2_q <= 4'd9) && (count_q != 3'd4)) begin
                  digits_d = {digits_q[11:0], bcd_s2_q};
                  count_d  = count_q + 3'd1;
                  state_d  = S_ENTRY;
               end
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   // Registered outputs follow the state being entered, so they change on the
   // same edge as the state and the encoder is enabled from the first edge.
   always_comb begin
      load_req_d = (state_d == S_LOAD);
      enablen_d  = (state_d == S_LOAD);
   end

   assign tmr.digits      = digits_q;
   assign tmr.digit_count = count_q;
   assign tmr.load_req    = load_req_q;
   assign tmr.load_done   = load_done_q;
   assign enablen_o       = enablen_q;
   assign error_o         = error_q;

endmodule

// File: tb/tb_keypad_digit_buffer.sv
// Scoreboard bench for keypad_digit_buffer: stimulus tasks update a digit-list
// model and push the expected output snapshot with the cycle it must appear;
// a monitor pops and compares whenever the DUT's visible outputs change.
module tb_keypad_digit_buffer;
   localparam int D = 2;

   logic       clk = 1'b0;
   logic       resetn = 1'b0;
   logic [3:0] bcd_i = 4'd0;
   logic       valid_data_i = 1'b0;
   logic       clear_i = 1'b0;
   logic       start_i = 1'b0;
   logic       enablen_o;
   logic       error_o;

   keypad_digit_buffer_if tmr_if ();

   keypad_digit_buffer #(.DEBOUNCE_CYCLES(D), .CNT_W(8)) dut (
      .clk          (clk),
      .resetn       (resetn),
      .bcd_i        (bcd_i),
      .valid_data_i (valid_data_i),
      .clear_i      (clear_i),
      .start_i      (start_i),
      .enablen_o    (enablen_o),
      .error_o      (error_o),
      .tmr          (tmr_if.master)
   );

   always #5 clk = ~clk;

   typedef struct {
      int          cyc;
      logic [15:0] dig;
      logic [2:0]  cnt;
      bit          req, enb, err, done;
   } ev_t;

   ev_t  exp_q[$];
   int   compared = 0;
   int   mismatched = 0;
   int   cyc = 0;
   bit   mon_en = 1'b0;

   // model: list of entered digits plus a coarse phase (0 idle, 1 entry, 2 load)
   int   m_dig[$];
   int   m_state = 0;

   always @(posedge clk) cyc++;

   function automatic logic [15:0] m_val();
      logic [15:0] v = 16'h0;
      foreach (m_dig[i]) v = (v << 4) | 16'(m_dig[i]);
      return v;
   endfunction

   function automatic void push_ev(int c, bit req, bit err, bit done);
      ev_t e;
      e.cyc = c; e.dig = m_val(); e.cnt = 3'(m_dig.size());
      e.req = req; e.enb = req; e.err = err; e.done = done;
      exp_q.push_back(e);
   endfunction

   task automatic chk(string nm, logic [31:0] got, logic [31:0] want);
      compared++;
      if (got !== want) begin
         mismatched++;
         $display("FAIL %s got=%0h want=%0h", nm, got, want);
      end
   endtask

   // monitor
   logic [15:0] p_dig = 16'h0;
   logic [2:0]  p_cnt = 3'd0;
   logic        p_req = 1'b0;
   ev_t         me;
   always @(negedge clk) begin
      if (mon_en && resetn) begin
         if (error_o || tmr_if.load_done || tmr_if.digits != p_dig ||
             tmr_if.digit_count != p_cnt || tmr_if.load_req != p_req) begin
            compared++;
            if (exp_q.size() == 0) begin
               mismatched++;
               $display("FAIL unexpected_event cyc=%0d digits=%h cnt=%0d req=%b err=%b done=%b",
                        cyc, tmr_if.digits, tmr_if.digit_count, tmr_if.load_req, error_o, tmr_if.load_done);
            end else begin
               me = exp_q.pop_front();
               if (me.cyc != cyc || me.dig !== tmr_if.digits || me.cnt !== tmr_if.digit_count ||
                   me.req !== tmr_if.load_req || me.enb !== enablen_o ||
                   me.err !== error_o || me.done !== tmr_if.load_done) begin
                  mismatched++;
                  $display("FAIL event got cyc=%0d dig=%h cnt=%0d req=%b enb=%b err=%b done=%b want cyc=%0d dig=%h cnt=%0d req=%b enb=%b err=%b done=%b",
                           cyc, tmr_if.digits, tmr_if.digit_count, tmr_if.load_req, enablen_o, error_o, tmr_if.load_done,
                           me.cyc, me.dig, me.cnt, me.req, me.enb, me.err, me.done);
               end
            end
         end
      end
      p_dig = tmr_if.digits;
      p_cnt = tmr_if.digit_count;
      p_req = tmr_if.load_req;
   end

   // A press is first sampled at edge k; with hold >= D samples it is accepted
   // on edge k+1+D unless the model says it is suppressed or ignored.
   task automatic press(int d, int hold, int gap);
      int k;
      @(negedge clk);
      bcd_i = 4'(d);
      valid_data_i = 1'b1;
      k = cyc + 1;
      if (hold >= D && m_state != 2 && d <= 9 && m_dig.size() < 4) begin
         m_dig.push_back(d);
         m_state = 1;
         push_ev(k + 1 + D, 1'b0, 1'b0, 1'b0);
      end
      repeat (hold) @(negedge clk);
      valid_data_i = 1'b0;
      repeat (gap) @(negedge clk);
   endtask

   task automatic ctrl(bit c, bit s, bit a);
      int e;
      logic [15:0] v;
      repeat (D + 4) @(negedge clk);
      clear_i = c; start_i = s; tmr_if.load_ack = a;
      e = cyc + 1;
      v = m_val();
      if (c) begin
         if (m_dig.size() > 0 || m_state == 2) begin
            m_dig.delete(); m_state = 0;
            push_ev(e, 1'b0, 1'b0, 1'b0);
         end
      end else if (a && m_state == 2) begin
         m_dig.delete(); m_state = 0;
         push_ev(e, 1'b0, 1'b0, 1'b1);
      end else if (s && m_state != 2) begin
         if (m_dig.size() == 0 || v == 16'h0 || v[7:4] > 4'd5) begin
            push_ev(e, 1'b0, 1'b1, 1'b0);
         end else begin
            m_state = 2;
            push_ev(e, 1'b1, 1'b0, 1'b0);
         end
      end
      @(negedge clk);
      clear_i = 1'b0; start_i = 1'b0; tmr_if.load_ack = 1'b0;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog time limit cyc=%0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      int r, d;
      tmr_if.load_ack = 1'b0;
      #12;
      chk("reset_enablen", 32'(enablen_o), 32'd1);
      chk("reset_digits", 32'(tmr_if.digits), 32'h0);
      chk("reset_flags", {tmr_if.digit_count, tmr_if.load_req, tmr_if.load_done, error_o}, 32'h0);
      @(negedge clk);
      chk("reset_hold_enablen", 32'(enablen_o), 32'd1);
      resetn = 1'b1;
      @(posedge clk); #1;
      chk("release_enablen", 32'(enablen_o), 32'd0);
      @(negedge clk);
      mon_en = 1'b1;

      // entry with latency checked by the scoreboard
      press(1, 6, 3); press(3, 6, 3); press(0, 6, 3);
      repeat (D + 4) @(negedge clk);
      chk("entry_digits", 32'(tmr_if.digits), 32'h0130);
      chk("entry_count", 32'(tmr_if.digit_count), 32'd3);
      ctrl(1'b1, 1'b0, 1'b0);

      // glitch then overflow
      press(7, 1, 3);
      for (int i = 1; i <= 5; i++) press(i, 4, 3);
      repeat (D + 4) @(negedge clk);
      chk("overflow_digits", 32'(tmr_if.digits), 32'h1234);
      chk("overflow_count", 32'(tmr_if.digit_count), 32'd4);
      ctrl(1'b1, 1'b0, 1'b0);

      // rejected starts
      press(1, 4, 3); press(7, 4, 3); press(5, 4, 3);
      ctrl(1'b0, 1'b1, 1'b0);
      ctrl(1'b1, 1'b0, 1'b0);
      ctrl(1'b0, 1'b1, 1'b0);

      // handshake with a key pressed during LOAD
      press(1, 4, 3); press(3, 4, 3); press(0, 4, 3);
      ctrl(1'b0, 1'b1, 1'b0);
      chk("load_enablen", 32'(enablen_o), 32'd1);
      press(4, 5, 2);
      chk("load_digits_held", 32'(tmr_if.digits), 32'h0130);
      ctrl(1'b0, 1'b0, 1'b1);

      // priority: clear beats ack, clear beats start
      press(1, 4, 3); press(3, 4, 3); press(0, 4, 3);
      ctrl(1'b0, 1'b1, 1'b0);
      ctrl(1'b1, 1'b0, 1'b1);
      press(2, 4, 3);
      ctrl(1'b1, 1'b1, 1'b0);

      // asynchronous reset mid-entry
      press(1, 4, 3); press(2, 4, 3);
      repeat (D + 4) @(negedge clk);
      chk("pre_reset_digits", 32'(tmr_if.digits), 32'h0012);
      mon_en = 1'b0;
      #3 resetn = 1'b0;
      #1;
      chk("async_reset_digits", 32'(tmr_if.digits), 32'h0);
      chk("async_reset_count", 32'(tmr_if.digit_count), 32'd0);
      chk("async_reset_enablen", 32'(enablen_o), 32'd1);
      m_dig.delete(); m_state = 0;
      @(negedge clk);
      resetn = 1'b1;
      @(posedge clk); #1;
      chk("rerelease_enablen", 32'(enablen_o), 32'd0);
      @(negedge clk);
      mon_en = 1'b1;

      // randomized mix
      for (int n = 0; n < 60; n++) begin
         r = $urandom_range(0, 9);
         if (r <= 5) begin
            d = (r == 5) ? $urandom_range(0, 15) : $urandom_range(0, 9);
            press(d, $urandom_range(1, 5), $urandom_range(1, 3));
         end else if (r <= 7) ctrl(1'b0, 1'b1, 1'b0);
         else if (r == 8)     ctrl(1'b0, 1'b0, 1'b1);
         else                 ctrl(1'b1, 1'b0, 1'b0);
      end

      for (int t = 0; t < 40 && exp_q.size() > 0; t++) @(negedge clk);
      while (exp_q.size() > 0) begin
         me = exp_q.pop_front();
         compared++;
         mismatched++;
         $display("FAIL missing_event want cyc=%0d dig=%h cnt=%0d req=%b err=%b done=%b",
                  me.cyc, me.dig, me.cnt, me.req, me.err, me.done);
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule
